piso_serializer: RTL and testbench



---
 rtl/piso_pkg.sv | 15 +
 rtl/piso_serializer.sv | 121 ++++++++++++
 tb/tb_piso_serializer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in serial-out transmitter.
package piso_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;

   // Bits needed to count 0..width inclusive
   function automatic int unsigned cnt_w(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter, MSB first, paced by bit_en.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_en,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             busy,
   output logic             done
);

   localparam int unsigned   CW   = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             bit_valid_d;
   logic             busy_d;
   logic             done_d;
   logic             last_c;
   logic             accept_c;

`ifdef PISO_PARITY_EN
   logic             parity_q, parity_d;

   assign last_c = (state_q == PARITY);
`else
   assign last_c = (state_q == SHIFT) && (cnt_q == LAST);
`endif

   // Ready in IDLE, or as the final bit of a frame is consumed for gapless frames
   assign load_ready = rst & ((state_q == IDLE) | (last_c & bit_en));
   assign accept_c   = load_valid & load_ready;

   // The presented bit is the shift register MSB; it drains to zero at frame end
   assign bit_out = shreg_q[WIDTH-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         cnt_q     <= '0;
         bit_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef PISO_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         cnt_q     <= cnt_d;
         bit_valid <= bit_valid_d;
         busy      <= busy_d;
         done      <= done_d;
`ifdef PISO_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   // Next-state and output logic; bit_en low holds everything
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;
      bit_valid_d = bit_valid;
      done_d      = 1'b0;
`ifdef PISO_PARITY_EN
      parity_d    = parity_q;
`endif

      if (accept_c) begin
         state_d     = SHIFT;
         shreg_d     = data_in;
         cnt_d       = '0;
         bit_valid_d = 1'b1;
`ifdef PISO_PARITY_EN
         parity_d    = ^data_in;
`endif
      end else if (bit_en) begin
         case (state_q)
            SHIFT: begin
               shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
               cnt_d   = cnt_q + CW'(1);
               if (cnt_q == LAST) begin
`ifdef PISO_PARITY_EN
                  state_d = PARITY;
                  shreg_d = {parity_q, {(WIDTH-1){1'b0}}};
`else
                  state_d     = IDLE;
                  bit_valid_d = 1'b0;
                  done_d      = 1'b1;
`endif
               end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
               state_d     = IDLE;
               shreg_d     = '0;
               bit_valid_d = 1'b0;
               done_d      = 1'b1;
            end
`endif
            default: ;
         endcase
      end

      busy_d = (state_d != IDLE);
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: bit-level scoreboard plus frame vectors.
`timescale 1ns/1ps
module tb_piso_serializer;

   localparam int unsigned WIDTH = 16;
`ifdef PISO_PARITY_EN
   localparam int unsigned FRAME_BITS = WIDTH + 1;
`else
   localparam int unsigned FRAME_BITS = WIDTH;
`endif

   logic             clk;
   logic             rst;
   logic             bit_en;
   logic [WIDTH-1:0] data_in;
   logic             load_valid;
   logic             load_ready;
   logic             bit_out;
   logic             bit_valid;
   logic             busy;
   logic             done;

   piso_serializer #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .bit_en     (bit_en),
      .data_in    (data_in),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .bit_out    (bit_out),
      .bit_valid  (bit_valid),
      .busy       (busy),
      .done       (done)
   );

   typedef struct {
      logic [WIDTH-1:0] data;
      int unsigned      period;
      int unsigned      ones;
      logic             par;
   } vec_t;

   vec_t        vecs [5];
   int          tests_run    = 0;
   int          tests_failed = 0;
   bit          exp_q [$];
   logic        exp_done     = 1'b0;
   int          bits_seen    = 0;
   int          ones_seen    = 0;
   int          done_cnt     = 0;
   logic        last_bit     = 1'b0;
   logic        b2b_hit      = 1'b0;
   int unsigned en_period    = 1;
   int unsigned cyc          = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // bit_en pacing: high one cycle in en_period
   initial begin
      bit_en = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         bit_en = ((cyc % en_period) == 0);
      end
   end

   // Scoreboard: queue holds the bits still to be presented, front = current bit
   initial begin
      int  sz;
      logic exp_ready, cons, acc;
      bit  b;
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("rst_bit_valid", bit_valid, 0);
            check("rst_bit_out", bit_out, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_load_ready", load_ready, 0);
            exp_q.delete();
            exp_done = 1'b0;
         end else begin
            sz        = exp_q.size();
            exp_ready = (sz == 0) || (sz == 1 && bit_en);
            check("done", done, exp_done);
            if (done) done_cnt++;
            check("bit_valid", bit_valid, sz != 0);
            check("busy", busy, sz != 0);
            check("load_ready", load_ready, exp_ready);
            check("bit_out", bit_out, (sz != 0) ? exp_q[0] : 1'b0);
            cons     = (sz != 0) && bit_en;
            acc      = load_valid && exp_ready;
            exp_done = cons && (sz == 1) && !acc;
            if (cons) begin
               b = exp_q.pop_front();
               bits_seen++;
               ones_seen += int'(b);
               last_bit = b;
            end
            if (acc) begin
               if (sz != 0) b2b_hit = 1'b1;
               for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(data_in[i]);
`ifdef PISO_PARITY_EN
               exp_q.push_back(^data_in);
`endif
            end
         end
      end
   end

   task automatic send(input logic [WIDTH-1:0] d, input bit keep);
      bit ok = 1'b0;
      data_in    = d;
      load_valid = 1'b1;
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (load_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("load_timeout", 0, 1);
      @(posedge clk);
      #1;
      if (!keep) load_valid = 1'b0;
   endtask

   task automatic wait_done(output int len);
      bit ok = 1'b0;
      len = 0;
      for (int n = 1; n < 2000; n++) begin
         @(negedge clk);
         if (done) begin
            ok  = 1'b1;
            len = n;
            break;
         end
      end
      if (!ok) check("done_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      bits_seen = 0;
      ones_seen = 0;
      done_cnt  = 0;
      b2b_hit   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int len;
      bit ok;

      vecs[0] = '{data: 16'hA5C3, period: 1, ones: 8,  par: 1'b0};
      vecs[1] = '{data: 16'h8001, period: 4, ones: 2,  par: 1'b0};
      vecs[2] = '{data: 16'h1234, period: 2, ones: 5,  par: 1'b1};
      vecs[3] = '{data: 16'h0001, period: 1, ones: 1,  par: 1'b1};
      vecs[4] = '{data: 16'hFFFF, period: 3, ones: 16, par: 1'b0};

      rst        = 1'b0;
      data_in    = '0;
      load_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("idle_ready", load_ready, 1);
      check("idle_valid", bit_valid, 0);

      // Single frames from the vector table
      for (int i = 0; i < 5; i++) begin
         en_period = vecs[i].period;
         clear_stats();
         send(vecs[i].data, 1'b0);
         wait_done(len);
         if (vecs[i].period == 1) check("frame_len", len, FRAME_BITS + 1);
         check("frame_bits", bits_seen, FRAME_BITS);
         check("done_count", done_cnt, 1);
`ifdef PISO_PARITY_EN
         check("frame_ones", ones_seen, vecs[i].ones + int'(vecs[i].par));
         check("parity_bit", last_bit, vecs[i].par);
`else
         check("frame_ones", ones_seen, vecs[i].ones);
         check("last_bit", last_bit, vecs[i].data[0]);
`endif
      end

      // Back-to-back frames with load_valid held high
      en_period = 1;
      clear_stats();
      send(16'hFFFF, 1'b1);
      send(16'h0000, 1'b0);
      wait_done(len);
      check("b2b_bits", bits_seen, 2 * FRAME_BITS);
      check("b2b_ones", ones_seen, 16);
      check("b2b_done_count", done_cnt, 1);
      check("b2b_no_gap", b2b_hit, 1);

      // Reset in the middle of a frame
      clear_stats();
      send(16'hA5C3, 1'b0);
      ok = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (bits_seen >= 5) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("midrst_timeout", 0, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("midrst_valid", bit_valid, 0);
      check("midrst_out", bit_out, 0);
      check("midrst_busy", busy, 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("midrst_no_done", done_cnt, 0);
      clear_stats();
      send(16'h1234, 1'b0);
      wait_done(len);
      check("postrst_len", len, FRAME_BITS + 1);
      check("postrst_bits", bits_seen, FRAME_BITS);
`ifdef PISO_PARITY_EN
      check("postrst_ones", ones_seen, 6);
`else
      check("postrst_ones", ones_seen, 5);
`endif

      // Word held on load_valid during a paced frame is taken only when ready
      en_period = 2;
      clear_stats();
      send(16'hA5C3, 1'b0);
      send(16'h5555, 1'b0);
      wait_done(len);
      check("stall_bits", bits_seen, 2 * FRAME_BITS);
      check("stall_ones", ones_seen, 16);
      check("stall_done_count", done_cnt, 1);
      check("stall_b2b", b2b_hit, 1);

      repeat (3) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
